// File: rtl/sdram_access_arbiter.sv
// Boots the SDRAM controller, then grants one full-row burst at a time to a writer or reader.
// Optional watchdog on grant/burst states: define SDRAM_ARB_WATCHDOG_EN.
module sdram_access_arbiter #(
  parameter int unsigned ROWS       = 4096,
  parameter int unsigned BURST_LEN  = 256,
  parameter int unsigned WDT_CYCLES = 4096
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     boot_i,
  input  logic                     wr_req_i,
  input  logic                     rd_req_i,
  output logic                     wr_grant_o,
  output logic                     rd_grant_o,
  output logic                     wr_done_o,
  output logic                     rd_done_o,
  output logic [$clog2(ROWS):0]    fill_level_o,
  output logic                     ctrl_start_o,
  output logic                     ctrl_write_mode_o,
  output logic                     ctrl_read_mode_o,
  input  logic                     ctrl_tx_active_i,
  input  logic                     ctrl_rx_active_i,
  input  logic                     ctrl_init_done_i,
  output logic                     ready_o,
  output logic                     burst_err_o,
  output logic                     timeout_o
);

  localparam int unsigned FillW = $clog2(ROWS) + 1;
  localparam int unsigned CntW  = $clog2(BURST_LEN + 1) + 1;

  typedef enum logic [2:0] {
    StIdle, StInit, StArb, StWrReq, StWrBurst, StRdReq, StRdBurst, StGap
  } state_e;

  state_e            state_q, state_d;
  logic [FillW-1:0]  fill_q, fill_d;
  logic [CntW-1:0]   cnt_q, cnt_d, cnt_inc;
  logic              last_wr_q, last_wr_d;
  logic              err_q, err_d;
  logic              ready_q, ready_d;
  logic              start_q, start_d;
  logic              wr_done_q, wr_done_d;
  logic              rd_done_q, rd_done_d;
  logic              tx_q, rx_q;
  logic              wr_elig, rd_elig, unexpected;

`ifdef SDRAM_ARB_WATCHDOG_EN
  localparam int unsigned WdtW = $clog2(WDT_CYCLES + 1);
  logic [WdtW-1:0]   wdt_q, wdt_d;
  logic              timeout_q, timeout_d;
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      fill_q    <= '0;
      cnt_q     <= '0;
      last_wr_q <= 1'b0;
      err_q     <= 1'b0;
      ready_q   <= 1'b0;
      start_q   <= 1'b0;
      wr_done_q <= 1'b0;
      rd_done_q <= 1'b0;
      tx_q      <= 1'b0;
      rx_q      <= 1'b0;
`ifdef SDRAM_ARB_WATCHDOG_EN
      wdt_q     <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      fill_q    <= fill_d;
      cnt_q     <= cnt_d;
      last_wr_q <= last_wr_d;
      err_q     <= err_d;
      ready_q   <= ready_d;
      start_q   <= start_d;
      wr_done_q <= wr_done_d;
      rd_done_q <= rd_done_d;
      tx_q      <= ctrl_tx_active_i;
      rx_q      <= ctrl_rx_active_i;
`ifdef SDRAM_ARB_WATCHDOG_EN
      wdt_q     <= wdt_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  assign wr_elig    = wr_req_i && (fill_q < FillW'(ROWS));
  assign rd_elig    = rd_req_i && (fill_q != '0);
  assign cnt_inc    = (cnt_q == '1) ? cnt_q : cnt_q + CntW'(1);
  assign unexpected = ((state_q == StArb || state_q == StGap) &&
                       (ctrl_tx_active_i || ctrl_rx_active_i)) ||
                      (ctrl_tx_active_i && ctrl_rx_active_i);

  always_comb begin
    state_d   = state_q;
    fill_d    = fill_q;
    cnt_d     = cnt_q;
    last_wr_d = last_wr_q;
    err_d     = err_q | unexpected;
    ready_d   = ready_q;
    start_d   = 1'b0;
    wr_done_d = 1'b0;
    rd_done_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (boot_i) begin
          start_d = 1'b1;
          state_d = StInit;
        end
      end
      StInit: begin
        if (ctrl_init_done_i) begin
          ready_d = 1'b1;
          state_d = StArb;
        end
      end
      StArb: begin
        cnt_d = '0;
        if (wr_elig && rd_elig) state_d = last_wr_q ? StRdReq : StWrReq;
        else if (wr_elig)       state_d = StWrReq;
        else if (rd_elig)       state_d = StRdReq;
      end
      StWrReq: begin
        // The rising cycle is the first counted word of the burst.
        if (ctrl_tx_active_i && !tx_q) begin
          cnt_d   = CntW'(1);
          state_d = StWrBurst;
        end
      end
      StWrBurst: begin
        if (ctrl_tx_active_i) begin
          cnt_d = cnt_inc;
        end else begin
          if (cnt_q != CntW'(BURST_LEN)) err_d = 1'b1;
          wr_done_d = 1'b1;
          fill_d    = fill_q + FillW'(1);
          last_wr_d = 1'b1;
          state_d   = StGap;
        end
      end
      StRdReq: begin
        if (ctrl_rx_active_i && !rx_q) begin
          cnt_d   = CntW'(1);
          state_d = StRdBurst;
        end
      end
      StRdBurst: begin
        if (ctrl_rx_active_i) begin
          cnt_d = cnt_inc;
        end else begin
          if (cnt_q != CntW'(BURST_LEN)) err_d = 1'b1;
          rd_done_d = 1'b1;
          fill_d    = fill_q - FillW'(1);
          last_wr_d = 1'b0;
          state_d   = StGap;
        end
      end
      StGap:   state_d = StArb;
      default: state_d = StIdle;
    endcase

`ifdef SDRAM_ARB_WATCHDOG_EN
    timeout_d = 1'b0;
    wdt_d     = '0;
    if (state_q == StWrReq || state_q == StWrBurst ||
        state_q == StRdReq || state_q == StRdBurst) begin
      wdt_d = wdt_q + WdtW'(1);
      // Abandon the transfer: no done pulse and no fill change.
      if (wdt_q == WdtW'(WDT_CYCLES - 1)) begin
        timeout_d = 1'b1;
        err_d     = 1'b1;
        wr_done_d = 1'b0;
        rd_done_d = 1'b0;
        fill_d    = fill_q;
        last_wr_d = last_wr_q;
        state_d   = StGap;
      end
    end
`endif
  end

  assign wr_grant_o        = (state_q == StWrReq) || (state_q == StWrBurst);
  assign rd_grant_o        = (state_q == StRdReq) || (state_q == StRdBurst);
  assign ctrl_write_mode_o = (state_q == StWrReq);
  assign ctrl_read_mode_o  = (state_q == StRdReq);
  assign wr_done_o         = wr_done_q;
  assign rd_done_o         = rd_done_q;
  assign fill_level_o      = fill_q;
  assign ctrl_start_o      = start_q;
  assign ready_o           = ready_q;
  assign burst_err_o       = err_q;
`ifdef SDRAM_ARB_WATCHDOG_EN
  assign timeout_o         = timeout_q;
`else
  assign timeout_o         = 1'b0;
`endif

endmodule
